// File: rtl/lcd_timing_ctrl_pkg.sv
// Shared video types: LCD mode encoding, default frame timing and counter widths.
package video_types;

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        XFER     = 2'd3
    } LcdMode;

    localparam int unsigned LCD_DOTS_PER_LINE = 456;
    localparam int unsigned LCD_OAM_DOTS      = 80;
    localparam int unsigned LCD_XFER_DOTS     = 172;
    localparam int unsigned LCD_VISIBLE_LINES = 144;
    localparam int unsigned LCD_TOTAL_LINES   = 154;
    localparam int unsigned LCD_LINES_BITS    = 8;
    localparam int unsigned LCD_DOTS_BITS     = 9;

    // Mode of a given (line, dot) position; the bounds are the first dot/line past each region.
    function automatic LcdMode lcd_mode_of(
        input logic [LCD_DOTS_BITS-1:0]  dot,
        input logic [LCD_LINES_BITS-1:0] ly,
        input logic [LCD_DOTS_BITS-1:0]  oam_end,
        input logic [LCD_DOTS_BITS-1:0]  xfer_end,
        input logic [LCD_LINES_BITS-1:0] vis_end
    );
        LcdMode m;
        if (ly >= vis_end) begin
            m = VBLANK;
        end else if (dot < oam_end) begin
            m = OAM_SCAN;
        end else if (dot < xfer_end) begin
            m = XFER;
        end else begin
            m = HBLANK;
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_timing_ctrl_stat_irq.sv
// STAT interrupt source combiner with rising-edge detection of the combined STAT line.
module lcd_stat_irq
    import video_types::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_i,
    input  logic       fire_i,
    input  logic [3:0] stat_ie_i,
    input  logic       coincidence_i,
    input  LcdMode     mode_i,
    output logic       irq_o
);

    logic stat_line;
    logic line_q;
    logic irq_q;

    always_comb begin
        stat_line = (stat_ie_i[3] & coincidence_i)
                  | (stat_ie_i[2] & (mode_i == OAM_SCAN))
                  | (stat_ie_i[1] & (mode_i == VBLANK))
                  | (stat_ie_i[0] & (mode_i == HBLANK));
    end

    // History only moves on sampling cycles so an edge seen while dots are gated is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (sample_i) begin
                line_q <= stat_line;
            end
            irq_q <= fire_i & stat_line & ~line_q;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD dot/line sequencer: LY, STAT mode, coincidence, draw/VBlank/frame strobes and bus busy flags.
// Optional STAT interrupt logic is built when LCD_STAT_IRQ_EN is defined.
module lcd_timing_ctrl
    import video_types::*;
#(
    parameter int unsigned DOTS_PER_LINE = LCD_DOTS_PER_LINE,
    parameter int unsigned OAM_DOTS      = LCD_OAM_DOTS,
    parameter int unsigned XFER_DOTS     = LCD_XFER_DOTS,
    parameter int unsigned VISIBLE_LINES = LCD_VISIBLE_LINES,
    parameter int unsigned TOTAL_LINES   = LCD_TOTAL_LINES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dot_en,
    input  logic                      lcd_en,
    input  logic [7:0]                lyc,
    input  logic [3:0]                stat_ie,
    output logic [LCD_LINES_BITS-1:0] ly,
    output logic [1:0]                mode,
    output logic                      coincidence,
    output logic                      drawline,
    output logic                      frame_done,
    output logic                      vblank_irq,
    output logic                      stat_irq,
    output logic                      vram_busy,
    output logic                      oam_busy
);

    localparam logic [LCD_DOTS_BITS-1:0]  DotLast  = LCD_DOTS_BITS'(DOTS_PER_LINE - 1);
    localparam logic [LCD_DOTS_BITS-1:0]  OamEnd   = LCD_DOTS_BITS'(OAM_DOTS);
    localparam logic [LCD_DOTS_BITS-1:0]  XferEnd  = LCD_DOTS_BITS'(OAM_DOTS + XFER_DOTS);
    localparam logic [LCD_DOTS_BITS-1:0]  XferLast = LCD_DOTS_BITS'(OAM_DOTS + XFER_DOTS - 1);
    localparam logic [LCD_LINES_BITS-1:0] VisEnd   = LCD_LINES_BITS'(VISIBLE_LINES);
    localparam logic [LCD_LINES_BITS-1:0] VisLast  = LCD_LINES_BITS'(VISIBLE_LINES - 1);
    localparam logic [LCD_LINES_BITS-1:0] LineLast = LCD_LINES_BITS'(TOTAL_LINES - 1);

    logic [LCD_DOTS_BITS-1:0]  dot_q, dot_d;
    logic [LCD_LINES_BITS-1:0] ly_q, ly_d;
    LcdMode                    mode_q, mode_d;
    logic                      draw_q, draw_d;
    logic                      vblank_q, vblank_d;
    logic                      frame_q, frame_d;
    logic                      oam_busy_q, vram_busy_q;
    logic                      coinc_q;
    logic                      last_dot;
    logic                      last_line;

    always_comb begin
        dot_d     = dot_q;
        ly_d      = ly_q;
        mode_d    = mode_q;
        draw_d    = 1'b0;
        vblank_d  = 1'b0;
        frame_d   = 1'b0;
        last_dot  = (dot_q == DotLast);
        last_line = (ly_q == LineLast);

        if (reset || !lcd_en) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = HBLANK;
        end else if (dot_en) begin
            if (last_dot) begin
                dot_d = '0;
                ly_d  = last_line ? '0 : ly_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
            mode_d   = lcd_mode_of(dot_d, ly_d, OamEnd, XferEnd, VisEnd);
            draw_d   = (dot_q == XferLast) && (ly_q < VisEnd);
            vblank_d = last_dot && (ly_q == VisLast);
            frame_d  = last_dot && last_line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dot_q       <= '0;
            ly_q        <= '0;
            mode_q      <= HBLANK;
            draw_q      <= 1'b0;
            vblank_q    <= 1'b0;
            frame_q     <= 1'b0;
            oam_busy_q  <= 1'b0;
            vram_busy_q <= 1'b0;
        end else begin
            dot_q       <= dot_d;
            ly_q        <= ly_d;
            mode_q      <= mode_d;
            draw_q      <= draw_d;
            vblank_q    <= vblank_d;
            frame_q     <= frame_d;
            oam_busy_q  <= (mode_d == OAM_SCAN) || (mode_d == XFER);
            vram_busy_q <= (mode_d == XFER);
        end
    end

    // Coincidence tracks the freshly updated line every cycle, even while dots are gated.
    always_ff @(posedge clk) begin
        coinc_q <= (ly_d == lyc);
    end

    assign ly          = ly_q;
    assign mode        = mode_q;
    assign coincidence = coinc_q;
    assign drawline    = draw_q;
    assign vblank_irq  = vblank_q;
    assign frame_done  = frame_q;
    assign oam_busy    = oam_busy_q;
    assign vram_busy   = vram_busy_q;

`ifdef LCD_STAT_IRQ_EN
    lcd_stat_irq u_stat_irq (
        .clk_i         (clk),
        .rst_i         (reset),
        .sample_i      (dot_en | ~lcd_en),
        .fire_i        (dot_en & lcd_en),
        .stat_ie_i     (stat_ie),
        .coincidence_i (coinc_q),
        .mode_i        (mode_q),
        .irq_o         (stat_irq)
    );
`else
    logic unused_stat_ie;
    assign unused_stat_ie = ^stat_ie;
    assign stat_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl: vector table plus one full-frame sequence.
module tb_lcd_timing_ctrl;

`ifdef LCD_STAT_IRQ_EN
    localparam bit StatOn = 1'b1;
`else
    localparam bit StatOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dot_en = 1'b0;
    logic       lcd_en = 1'b0;
    logic [7:0] lyc = 8'd0;
    logic [3:0] stat_ie = 4'd0;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       coincidence, drawline, frame_done, vblank_irq, stat_irq, vram_busy, oam_busy;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_timing_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .dot_en      (dot_en),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .stat_ie     (stat_ie),
        .ly          (ly),
        .mode        (mode),
        .coincidence (coincidence),
        .drawline    (drawline),
        .frame_done  (frame_done),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq),
        .vram_busy   (vram_busy),
        .oam_busy    (oam_busy)
    );

    typedef struct {
        logic       rst;
        logic       lcd;
        logic       den;
        logic [7:0] lyc;
        int         cyc;
        int         e_ly;
        int         e_mode;
        int         e_oam;
        int         e_vram;
        int         e_coinc;
        int         e_draw;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_mode(input int d, input int l);
        if (l >= 144) return 1;
        if (d < 80) return 2;
        if (d < 252) return 3;
        return 0;
    endfunction

    int m_dot, m_ly, m_mode;
    int ly_err, mode_err, busy_err, coinc_err;
    int draw_cnt, draw_first_n, draw_first_ly;
    int vbl_cnt, vbl_n, vbl_ly, fd_cnt, fd_n;
    int st_ly0, st_ly1_8, st_ly9, st_ly10, st_ly10_dot, st_ly11_143, st_hi, st_total;

    initial begin
        //           rst   lcd   den   lyc   cyc  ly md oam vram co draw
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 2,   0, 0, 0, 0,  1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd5, 1,   0, 2, 1, 0,  0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'd5, 78,  0, 2, 1, 0,  0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'd5, 1,   0, 3, 1, 1,  0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'd5, 171, 0, 3, 1, 1,  0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'd5, 1,   0, 0, 0, 0,  0, 1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'd5, 203, 0, 0, 0, 0,  0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'd5, 1,   1, 2, 1, 0,  0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd5, 20,  1, 2, 1, 0,  0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'd1, 1,   1, 2, 1, 0,  1, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd1, 1,   0, 0, 0, 0,  0, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'd0, 1,   0, 2, 1, 0,  1, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'd0, 1,   0, 0, 0, 0,  1, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd3, 1,   0, 0, 0, 0,  0, 0};

        for (int i = 0; i < 14; i++) begin
            reset  = vecs[i].rst;
            lcd_en = vecs[i].lcd;
            dot_en = vecs[i].den;
            lyc    = vecs[i].lyc;
            for (int c = 0; c < vecs[i].cyc; c++) tick();
            chk($sformatf("v%0d ly", i), int'(ly), vecs[i].e_ly);
            chk($sformatf("v%0d mode", i), int'(mode), vecs[i].e_mode);
            chk($sformatf("v%0d oam_busy", i), int'(oam_busy), vecs[i].e_oam);
            chk($sformatf("v%0d vram_busy", i), int'(vram_busy), vecs[i].e_vram);
            chk($sformatf("v%0d coincidence", i), int'(coincidence), vecs[i].e_coinc);
            chk($sformatf("v%0d drawline", i), int'(drawline), vecs[i].e_draw);
            chk($sformatf("v%0d pulses", i),
                int'({vblank_irq, frame_done, stat_irq}), 0);
        end

        // Full frame from reset, STAT enables switched at quiet points along the way.
        reset = 1'b1; lcd_en = 1'b1; dot_en = 1'b1; lyc = 8'd10; stat_ie = 4'b0001;
        tick(); tick();
        reset = 1'b0;
        ly_err = 0; mode_err = 0; busy_err = 0; coinc_err = 0;
        draw_cnt = 0; draw_first_n = -1; draw_first_ly = -1;
        vbl_cnt = 0; vbl_n = -1; vbl_ly = -1; fd_cnt = 0; fd_n = -1;
        st_ly0 = 0; st_ly1_8 = 0; st_ly9 = 0; st_ly10 = 0; st_ly10_dot = -1;
        st_ly11_143 = 0; st_hi = 0; st_total = 0;
        for (int n = 1; n <= 70224; n++) begin
            tick();
            m_dot  = n % 456;
            m_ly   = (n / 456) % 154;
            m_mode = model_mode(m_dot, m_ly);
            if (int'(ly) != m_ly) ly_err++;
            if (int'(mode) != m_mode) mode_err++;
            if (oam_busy != (m_mode >= 2) || vram_busy != (m_mode == 3)) busy_err++;
            if (coincidence != (m_ly == 10)) coinc_err++;
            if (drawline) begin
                draw_cnt++;
                if (draw_first_n < 0) begin
                    draw_first_n  = n;
                    draw_first_ly = int'(ly);
                end
            end
            if (vblank_irq) begin
                vbl_cnt++;
                vbl_n  = n;
                vbl_ly = int'(ly);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_n = n;
            end
            if (stat_irq) begin
                st_total++;
                if (m_ly == 0) st_ly0++;
                else if (m_ly <= 8) st_ly1_8++;
                else if (m_ly == 9) st_ly9++;
                else if (m_ly == 10) begin
                    st_ly10++;
                    st_ly10_dot = m_dot;
                end else if (m_ly < 144) st_ly11_143++;
                else st_hi++;
            end
            if (m_ly == 9 && m_dot == 300) stat_ie = 4'b1000;
            if (m_ly == 11 && m_dot == 100) stat_ie = 4'b0011;
        end

        chk("frame ly track errors", ly_err, 0);
        chk("frame mode errors", mode_err, 0);
        chk("frame busy errors", busy_err, 0);
        chk("frame coincidence errors", coinc_err, 0);
        chk("drawline count", draw_cnt, 144);
        chk("first drawline cycle", draw_first_n, 252);
        chk("first drawline ly", draw_first_ly, 0);
        chk("vblank count", vbl_cnt, 1);
        chk("vblank cycle", vbl_n, 65664);
        chk("vblank ly", vbl_ly, 144);
        chk("frame_done count", fd_cnt, 1);
        chk("frame_done cycle", fd_n, 70224);
        chk("ly after frame", int'(ly), 0);
        chk("stat irq line 0", st_ly0, StatOn ? 2 : 0);
        chk("stat irq mode0 lines 1..8", st_ly1_8, StatOn ? 8 : 0);
        chk("stat irq line 9", st_ly9, StatOn ? 1 : 0);
        chk("stat irq lyc line 10", st_ly10, StatOn ? 1 : 0);
        chk("stat irq lyc dot", st_ly10_dot, StatOn ? 1 : -1);
        chk("stat irq lines 11..143", st_ly11_143, StatOn ? 133 : 0);
        chk("stat irq in vblank", st_hi, 0);
        chk("stat irq total", st_total, StatOn ? 145 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_timing_ctrl.md
# lcd_timing_ctrl

Dot/line sequencer for the video block. It walks the 154-line × 456-dot LCD frame and emits the per-line `drawline` strobe that makes the background renderer draw each visible line. It also maintains LY, the LY=LYC coincidence flag and the STAT mode bits, raises the VBlank and STAT interrupt pulses, and produces the busy flags the bus decoder uses to block CPU VRAM/OAM access while the renderer owns those memories.

## Interface
Parameters:
- `DOTS_PER_LINE`, 456, dots per line; total dot count.
- `OAM_DOTS`, 80, length of mode 2 (OAM scan) in dots.
- `XFER_DOTS`, 172, length of mode 3 (pixel transfer) in dots.
- `VISIBLE_LINES`, 144, number of rendered lines.
- `TOTAL_LINES`, 154, total lines per frame, visible plus VBlank.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `dot_en`  in  1  dot-clock enable; counters advance only on cycles where it is 1.
- `lcd_en`  in  1  LCDC bit 7.
- `lyc`  in  8  LYC register (FF45).
- `stat_ie`  in  4  STAT bits 6:3: {lyc, mode2, mode1, mode0} interrupt enables.
- `ly`  out  8  current line (FF44).
- `mode`  out  2  STAT mode: 0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer.
- `coincidence`  out  1  registered `ly == lyc`.
- `drawline`  out  1  one-cycle pulse telling the renderer to draw line `ly`.
- `frame_done`  out  1  one-cycle pulse at frame wrap.
- `vblank_irq`  out  1  one-cycle interrupt request (IF bit 0).
- `stat_irq`  out  1  one-cycle interrupt request (IF bit 1).
- `vram_busy`  out  1  CPU VRAM access blocked.
- `oam_busy`  out  1  CPU OAM access blocked.

## Operation
- Internal state: `dot` counter, 9 bits, range 0..455; `ly` counter, 8 bits, range 0..153.
- Advance rule (on a cycle with `dot_en`=1 and `lcd_en`=1):
  - `dot` increments.
  - At `dot`=455 it wraps to 0 and `ly` increments.
  - At `ly`=153 with `dot`=455, `ly` wraps to 0.
- Mode is derived from the next-state counters and registered:
  - `ly` < 144: `dot` < 80 → mode 2; `dot` < 252 → mode 3; else mode 0.
  - `ly` ≥ 144 → mode 1.
- Busy flags:
  - `oam_busy` = mode 2 or 3.
  - `vram_busy` = mode 3.
- Pulses. Each is high for exactly one `clk` cycle, only on an advancing cycle, and only when `lcd_en`=1:
  - `drawline`: on entry to mode 0 (`dot` 251→252) on lines 0..143. `ly` is stable and equals the line to draw during the pulse.
  - `vblank_irq`: on entry to line 144 at dot 0.
  - `frame_done`: on the 153/455 → 0/0 wrap.
- `coincidence` updates every cycle, regardless of `dot_en` and `lcd_en`.
- STAT line = (`stat_ie`[3] & `coincidence`) | (`stat_ie`[2] & mode==2) | (`stat_ie`[1] & mode==1) | (`stat_ie`[0] & mode==0).
  - `stat_irq` pulses on the 0→1 edge of the STAT line only.
  - Mode transitions between two enabled sources keep the line high and produce no second pulse.
- LCD disable (`lcd_en`=0):
  - Next cycle: `dot`=0, `ly`=0, `mode`=0, busy flags 0, no pulses.
  - On re-enable: first advancing cycle is line 0, dot 1, mode 2. No `vblank_irq` is issued for the partial frame.
- Reset mid-frame has the same effect as LCD disable, and reset has priority over everything.

## Timing
- Reset values: `ly`=0, `mode`=0, `coincidence`=(`lyc`==0) from the first cycle after reset, all pulses 0, `vram_busy`=`oam_busy`=0, STAT line history 0.
- All outputs are registered, with zero additional latency: they reflect the counter state updated on the same edge.
- `dot_en`=0: all state holds and pulses are forced to 0.
- A `lyc` write becomes visible in `coincidence` one cycle later. `stat_irq` follows one cycle after that if the edge qualifies.
- Frame length is 456 × 154 = 70224 advancing cycles between `frame_done` pulses.

## Configuration
- `LCD_STAT_IRQ_EN` defined: STAT line logic and edge detector are built as described.
- Not defined: `stat_irq` is tied to 0 and `stat_ie` is unused. All other outputs are unchanged.

## Structure
- Shared package `video_types` holds:
  - `LcdMode` enum (HBLANK=0, VBLANK=1, OAM_SCAN=2, XFER=3).
  - Default timing constants for the five parameters.
  - `LCD_LINES_BITS`.
- One sub-module, `lcd_stat_irq`: combines the STAT sources and performs rising-edge detection. It is instantiated only under `LCD_STAT_IRQ_EN`.

## Test plan
- Reset, then `lcd_en`=1, `dot_en`=1 for 80 cycles → mode 2 on dots 1..79, mode 3 at dot 80, `oam_busy`=`vram_busy`=1.
- Run one line → `drawline` single pulse at `dot`=252 with `ly`=0; `ly`=1 after 456 cycles.
- Run 70224 cycles → `vblank_irq` once at `ly`=144 dot 0, 144 `drawline` pulses, `frame_done` once, `ly` back to 0.
- `lyc`=10, `stat_ie`=4'b1000 → `coincidence` high for all of line 10, exactly one `stat_irq` at line 10 entry.
- `stat_ie`=4'b0011 → mode 0→1 at line 144 yields no `stat_irq` (line stays high); with `stat_ie`=4'b0001 alone → 144 pulses per frame.
- Drop `lcd_en` at `ly`=50, dot 100 → next cycle `ly`=0, `mode`=0, no pulses; re-enable → line 0 mode 2, no spurious `vblank_irq`. Also: hold `dot_en`=0 for 20 cycles mid-line → counters frozen, no pulses.
